// File: rtl/ddcb_pkg.sv
// ddcb_pkg
// Shared definitions for the DDCB cascade delay controller.
//   SEL_BYP / SEL_1BUF / SEL_2BUF : 2-bit per-stage mux select codes
//                                   (bit 0 -> S0, bit 1 -> S1)
//   sweep_state_t                 : states of the optional sweep engine
// The sweep engine is built only when DDCB_SWEEP_EN is defined.
package ddcb_pkg;

  localparam logic [1:0] SEL_BYP  = 2'b00;
  localparam logic [1:0] SEL_1BUF = 2'b01;
  localparam logic [1:0] SEL_2BUF = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/delay_code_enc.sv
// delay_code_enc
// Combinational delay code to per-stage select encoder.
// Ports:
//   code : delay in buffer units. Codes above 2*NMBR_CASCADES are clamped.
//   sel  : NMBR_CASCADES 2-bit selects. Stage g occupies bits [g*2 +: 2].
// The high-index stages take two buffers first. A single odd buffer lands
// on the next stage down, so bypass stages always sit at the low-index end.
module delay_code_enc
  import ddcb_pkg::*;
#(
  parameter  int NMBR_CASCADES = 4,
  localparam int CODE_W        = $clog2(2*NMBR_CASCADES+1)
) (
  input  logic [CODE_W-1:0]          code,
  output logic [NMBR_CASCADES*2-1:0] sel
);

  localparam int MAX_CODE = 2*NMBR_CASCADES;

  logic [CODE_W-1:0] code_clamped;

  assign code_clamped = (int'(code) > MAX_CODE) ? CODE_W'(MAX_CODE) : code;

  genvar gi;
  generate
    for (gi = 0; gi < NMBR_CASCADES; gi++) begin : g_stage
      // k counts stages from the top, so stage NMBR_CASCADES-1 fills first.
      localparam int K = NMBR_CASCADES - 1 - gi;
      assign sel[gi*2 +: 2] = (int'(code_clamped) >= 2*(K+1)) ? SEL_2BUF :
                              (int'(code_clamped) == 2*K+1)   ? SEL_1BUF :
                                                                SEL_BYP;
    end
  endgenerate

endmodule

// File: rtl/cascade_delay_ctrl.sv
// cascade_delay_ctrl
// Multi-channel controller for the DDCB programmable cascade delay lines.
// It turns a scalar delay code into registered per-stage selects.
// Optional macro: DDCB_SWEEP_EN builds the calibration sweep engine. Without
// it, only the direct-load path exists.
// Ports:
//   clk, rst_n               : clock and asynchronous active-low reset
//   cfg_valid / cfg_ready    : direct load handshake
//   cfg_ch, cfg_code         : target channel and delay code
//   sweep_start              : one-cycle start pulse (ignored unless idle)
//   sweep_ch                 : channel to sweep
//   sweep_lo, sweep_hi       : first and last sweep code
//   sweep_dwell              : each code is held for sweep_dwell+1 cycles
//   sweep_busy / sweep_done  : sweep in progress / one-cycle finish pulse
//   sel                      : registered selects. Channel c, stage g sits at
//                              [(c*NMBR_CASCADES+g)*2 +: 2].
`ifndef Nmbr_cascades
  `define Nmbr_cascades 4
`endif

module cascade_delay_ctrl
  import ddcb_pkg::*;
#(
  parameter  int NMBR_CASCADES = `Nmbr_cascades,
  parameter  int NMBR_CH       = 2,
  parameter  int DWELL_W       = 8,
  localparam int CODE_W        = $clog2(2*NMBR_CASCADES+1),
  localparam int CH_W          = (NMBR_CH > 1) ? $clog2(NMBR_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [CH_W-1:0]                 cfg_ch,
  input  logic [CODE_W-1:0]               cfg_code,
  input  logic                            sweep_start,
  input  logic [CH_W-1:0]                 sweep_ch,
  input  logic [CODE_W-1:0]               sweep_lo,
  input  logic [CODE_W-1:0]               sweep_hi,
  input  logic [DWELL_W-1:0]              sweep_dwell,
  output logic                            sweep_busy,
  output logic                            sweep_done,
  output logic [NMBR_CH*NMBR_CASCADES*2-1:0] sel
);

  localparam int SEL_W = NMBR_CASCADES*2;

  // Single write port into the select registers, shared by both paths.
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CODE_W-1:0] wr_code;
  logic              wr_ok;
  logic [SEL_W-1:0]  enc_sel;
  logic [SEL_W-1:0]  sel_reg [NMBR_CH];

  delay_code_enc #(.NMBR_CASCADES(NMBR_CASCADES)) u_enc (
    .code (wr_code),
    .sel  (enc_sel)
  );

  // Writes to channels that do not exist are dropped silently.
  assign wr_ok = wr_en && (int'(wr_ch) < NMBR_CH);

`ifdef DDCB_SWEEP_EN
  localparam int MAX_CODE = 2*NMBR_CASCADES;

  function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] c);
    return (int'(c) > MAX_CODE) ? CODE_W'(MAX_CODE) : c;
  endfunction

  sweep_state_t       state_reg;
  logic [CH_W-1:0]    ch_reg;
  logic [CODE_W-1:0]  hi_reg;
  logic [CODE_W-1:0]  code_reg;
  logic               up_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic [DWELL_W-1:0] cnt_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               start_acc;
  logic               step;
  logic [CODE_W-1:0]  lo_clamped;
  logic [CODE_W-1:0]  hi_clamped;
  logic [CODE_W-1:0]  code_next;

  assign lo_clamped = clamp_code(sweep_lo);
  assign hi_clamped = clamp_code(sweep_hi);
  assign start_acc  = (state_reg == IDLE) && sweep_start;
  assign step       = (state_reg == HOLD) && (cnt_reg == '0) && (code_reg != hi_reg);
  assign code_next  = up_reg ? code_reg + CODE_W'(1) : code_reg - CODE_W'(1);

  // A start pulse steals the write port, so a concurrent cfg load stalls.
  assign cfg_ready  = (state_reg == IDLE) && !sweep_start;
  assign sweep_busy = busy_reg;
  assign sweep_done = done_reg;

  always_comb begin
    wr_en   = 1'b0;
    wr_ch   = cfg_ch;
    wr_code = cfg_code;
    if (start_acc) begin
      wr_en   = 1'b1;
      wr_ch   = sweep_ch;
      wr_code = lo_clamped;
    end else if (step) begin
      wr_en   = 1'b1;
      wr_ch   = ch_reg;
      wr_code = code_next;
    end else if (cfg_valid && cfg_ready) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      hi_reg    <= '0;
      code_reg  <= '0;
      up_reg    <= 1'b1;
      dwell_reg <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (sweep_start) begin
            state_reg <= HOLD;
            ch_reg    <= sweep_ch;
            hi_reg    <= hi_clamped;
            code_reg  <= lo_clamped;
            up_reg    <= (lo_clamped <= hi_clamped);
            dwell_reg <= sweep_dwell;
            cnt_reg   <= sweep_dwell;
            busy_reg  <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - DWELL_W'(1);
          end else if (code_reg != hi_reg) begin
            code_reg <= code_next;
            cnt_reg  <= dwell_reg;
          end else begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end
`else
  // Sweep inputs are intentionally ignored in this build.
  logic unused_sweep;
  assign unused_sweep = ^{sweep_start, sweep_ch, sweep_lo, sweep_hi, sweep_dwell};

  assign cfg_ready  = 1'b1;
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;

  always_comb begin
    wr_en   = cfg_valid;
    wr_ch   = cfg_ch;
    wr_code = cfg_code;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NMBR_CH; c++) sel_reg[c] <= '0;
    end else if (wr_ok) begin
      for (int c = 0; c < NMBR_CH; c++) begin
        if (int'(wr_ch) == c) sel_reg[c] <= enc_sel;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NMBR_CH; gi++) begin : g_sel_out
      assign sel[gi*SEL_W +: SEL_W] = sel_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_cascade_delay_ctrl.sv
// tb_cascade_delay_ctrl
// Directed bench for cascade_delay_ctrl with NMBR_CASCADES=4, NMBR_CH=2.
// Expected selects per code (g3..g0, one channel byte):
//   0:00 1:40 2:80 3:90 4:A0 5:A4 6:A8 7:A9 8:AA
// Sweep checks are compiled only when DDCB_SWEEP_EN is defined. Otherwise
// the bench confirms that the sweep port is inert.
module tb_cascade_delay_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_ch;
  logic [3:0]  cfg_code;
  logic        sweep_start;
  logic [0:0]  sweep_ch;
  logic [3:0]  sweep_lo;
  logic [3:0]  sweep_hi;
  logic [7:0]  sweep_dwell;
  logic        sweep_busy;
  logic        sweep_done;
  logic [15:0] sel;

  int checks   = 0;
  int failures = 0;

  cascade_delay_ctrl #(.NMBR_CASCADES(4), .NMBR_CH(2), .DWELL_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_code    (cfg_code),
    .sweep_start (sweep_start),
    .sweep_ch    (sweep_ch),
    .sweep_lo    (sweep_lo),
    .sweep_hi    (sweep_hi),
    .sweep_dwell (sweep_dwell),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sel         (sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] load_code [4];
  logic [7:0] load_exp  [4];
`ifdef DDCB_SWEEP_EN
  logic [7:0] up_exp [4];
  logic [7:0] dn_exp [3];
`endif

  initial begin
    load_code[0] = 4'd0; load_exp[0] = 8'h00;
    load_code[1] = 4'd7; load_exp[1] = 8'hA9;
    load_code[2] = 4'd1; load_exp[2] = 8'h40;
    load_code[3] = 4'd8; load_exp[3] = 8'hAA;
`ifdef DDCB_SWEEP_EN
    up_exp[0] = 8'h80; up_exp[1] = 8'h90; up_exp[2] = 8'hA0; up_exp[3] = 8'hA4;
    dn_exp[0] = 8'hA8; dn_exp[1] = 8'hA4; dn_exp[2] = 8'hA0;
`endif

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_code = '0;
    sweep_start = 1'b0; sweep_ch = '0; sweep_lo = '0; sweep_hi = '0; sweep_dwell = '0;
    tick(); tick();
    $display("reset: sel=%h busy=%b done=%b ready=%b", sel, sweep_busy, sweep_done, cfg_ready);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_busy", 32'(sweep_busy), 32'h0);
    chk("reset_done", 32'(sweep_done), 32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Load ch1 with code 3.
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_code = 4'd3;
    #1 chk("load_ch1_ready", 32'(cfg_ready), 32'h1);
    tick();
    cfg_valid = 1'b0;
    $display("load ch1 code 3: sel=%h", sel);
    chk("load_ch1_code3", 32'(sel), 32'h9000);

    // Load ch0 with code 13, which clamps to 8.
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_code = 4'd13;
    tick();
    cfg_valid = 1'b0;
    $display("load ch0 code 13: sel=%h ready=%b", sel, cfg_ready);
    chk("load_ch0_clamp", 32'(sel), 32'h90AA);
    chk("clamp_ready", 32'(cfg_ready), 32'h1);

    // Table of direct loads on ch0, including both code bounds.
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_code = load_code[i];
      tick();
      cfg_valid = 1'b0;
      $display("load ch0 code %0d: sel=%h", load_code[i], sel);
      chk("load_table", 32'(sel), {16'h0, 8'h90, load_exp[i]});
    end

    // An idle cycle with no valid must not write.
    cfg_code = 4'd2;
    tick();
    chk("no_valid_hold", 32'(sel), 32'h90AA);

`ifdef DDCB_SWEEP_EN
    // Sweep ch0 2..5 with dwell 1. A cfg load to ch1 arrives in the same cycle.
    sweep_start = 1'b1; sweep_ch = 1'b0; sweep_lo = 4'd2; sweep_hi = 4'd5; sweep_dwell = 8'd1;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_code = 4'd8;
    #1 chk("start_vs_cfg_ready", 32'(cfg_ready), 32'h0);
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      $display("sweep up cycle %0d: sel=%h busy=%b done=%b ready=%b", i, sel, sweep_busy, sweep_done, cfg_ready);
      chk("sweep_up_sel", 32'(sel), {16'h0, 8'h90, up_exp[i/2]});
      chk("sweep_up_busy", 32'(sweep_busy), 32'h1);
      chk("sweep_up_done", 32'(sweep_done), 32'h0);
      chk("sweep_up_ready", 32'(cfg_ready), 32'h0);
      // A start pulse mid-sweep must be ignored.
      sweep_start = (i == 3); sweep_ch = 1'b1; sweep_lo = 4'd8; sweep_hi = 4'd0;
      tick();
      sweep_start = 1'b0;
    end
    $display("sweep up end: sel=%h busy=%b done=%b ready=%b", sel, sweep_busy, sweep_done, cfg_ready);
    chk("sweep_up_end_busy", 32'(sweep_busy), 32'h0);
    chk("sweep_up_end_done", 32'(sweep_done), 32'h1);
    chk("sweep_up_end_sel", 32'(sel), 32'h90A4);
    chk("sweep_up_end_ready", 32'(cfg_ready), 32'h0);
    tick();
    chk("after_done_pulse", 32'(sweep_done), 32'h0);
    chk("after_done_ready", 32'(cfg_ready), 32'h1);
    chk("after_done_no_write", 32'(sel), 32'h90A4);
    tick();
    cfg_valid = 1'b0;
    $display("stalled cfg completes: sel=%h", sel);
    chk("stalled_cfg_write", 32'(sel), 32'hAAA4);

    // Downward sweep on ch1: 6, 5, 4 with dwell 0.
    sweep_start = 1'b1; sweep_ch = 1'b1; sweep_lo = 4'd6; sweep_hi = 4'd4; sweep_dwell = 8'd0;
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      $display("sweep down cycle %0d: sel=%h busy=%b", i, sel, sweep_busy);
      chk("sweep_dn_sel", 32'(sel), {16'h0, dn_exp[i], 8'hA4});
      chk("sweep_dn_busy", 32'(sweep_busy), 32'h1);
      tick();
    end
    chk("sweep_dn_end_busy", 32'(sweep_busy), 32'h0);
    chk("sweep_dn_end_done", 32'(sweep_done), 32'h1);
    chk("sweep_dn_end_sel", 32'(sel), 32'hA0A4);
    tick();
    chk("sweep_dn_done_clear", 32'(sweep_done), 32'h0);

    // Reset in the middle of a long sweep on ch0.
    sweep_start = 1'b1; sweep_ch = 1'b0; sweep_lo = 4'd0; sweep_hi = 4'd8; sweep_dwell = 8'd3;
    tick();
    sweep_start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_sweep_busy", 32'(sweep_busy), 32'h1);
    chk("mid_sweep_sel", 32'(sel), 32'hA040);
    rst_n = 1'b0;
    #1;
    $display("async reset mid-sweep: sel=%h busy=%b", sel, sweep_busy);
    chk("async_rst_sel", 32'(sel), 32'h0);
    chk("async_rst_busy", 32'(sweep_busy), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    begin
      int done_seen = 0;
      int busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (sweep_done) done_seen++;
        if (sweep_busy) busy_seen++;
      end
      chk("post_rst_no_done", 32'(done_seen), 32'h0);
      chk("post_rst_no_busy", 32'(busy_seen), 32'h0);
      chk("post_rst_ready", 32'(cfg_ready), 32'h1);
      chk("post_rst_sel", 32'(sel), 32'h0);
    end
`else
    // Without the sweep engine the sweep port does nothing and cfg never stalls.
    sweep_start = 1'b1; sweep_ch = 1'b0; sweep_lo = 4'd2; sweep_hi = 4'd5; sweep_dwell = 8'd1;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_code = 4'd5;
    #1 chk("nosweep_ready", 32'(cfg_ready), 32'h1);
    tick();
    sweep_start = 1'b0; cfg_valid = 1'b0;
    $display("no-sweep start+cfg: sel=%h busy=%b done=%b", sel, sweep_busy, sweep_done);
    chk("nosweep_cfg_write", 32'(sel), 32'hA4AA);
    chk("nosweep_busy", 32'(sweep_busy), 32'h0);
    chk("nosweep_done", 32'(sweep_done), 32'h0);
    tick(); tick();
    chk("nosweep_sel_hold", 32'(sel), 32'hA4AA);

    // Asynchronous reset clears sel immediately.
    rst_n = 1'b0;
    #1 chk("async_rst_sel", 32'(sel), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
